// File: rtl/fifo_word_serializer_pkg.sv
// Shared definitions for the FIFO word-to-byte serializer: FSM encoding and
// helpers deriving the symbols-per-word count and byte index width.
package fifo_word_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      SEND    = 2'd3
   } state_t;

   function automatic int unsigned calc_nbytes(input int unsigned word_w,
                                               input int unsigned byte_w);
      return word_w / byte_w;
   endfunction

   function automatic int unsigned calc_idx_w(input int unsigned nbytes);
      return (nbytes <= 1) ? 1 : $clog2(nbytes);
   endfunction

endpackage

// File: rtl/fifo_word_serializer_if.sv
// FIFO read port plus byte-wide valid/ready transmit port of the serializer.
interface fifo_word_serializer_if #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned BYTE_W = 8
);
   logic [WORD_W-1:0] FifoData;
   logic              FifoEmpty;
   logic              FifoReadEn;
   logic [BYTE_W-1:0] TxData;
   logic              TxValid;
   logic              TxReady;

   modport master (
      input  FifoData, FifoEmpty, TxReady,
      output FifoReadEn, TxData, TxValid
   );

   modport slave (
      output FifoData, FifoEmpty, TxReady,
      input  FifoReadEn, TxData, TxValid
   );
endinterface

// File: rtl/fifo_word_serializer_piso_shift_reg.sv
// Parallel-in serial-out word buffer with byte index; presents one symbol at a
// time from the selected end and flags the final symbol of the word.
module piso_shift_reg
   import fifo_word_serializer_pkg::*;
#(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned BYTE_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic [BYTE_W-1:0] dout,
   output logic              last
);
   localparam int unsigned NBYTES = calc_nbytes(WORD_W, BYTE_W);
   localparam int unsigned IDX_W  = calc_idx_w(NBYTES);

   logic [WORD_W-1:0] buffer;
   logic [WORD_W-1:0] shifted;
   logic [IDX_W-1:0]  idx;

   // A single-symbol word never shifts, which also keeps the slices below legal.
   if (NBYTES <= 1) begin : g_single
      assign shifted = buffer;
   end else if (MSB_FIRST) begin : g_msb
      assign shifted = {buffer[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
   end else begin : g_lsb
      assign shifted = {{BYTE_W{1'b0}}, buffer[WORD_W-1:BYTE_W]};
   end

   if (MSB_FIRST) begin : g_out_msb
      assign dout = buffer[WORD_W-1 -: BYTE_W];
   end else begin : g_out_lsb
      assign dout = buffer[BYTE_W-1:0];
   end

   assign last = (idx == IDX_W'(NBYTES - 1));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         buffer <= '0;
         idx    <= '0;
      end else if (load) begin
         buffer <= din;
         idx    <= '0;
      end else if (shift && !last) begin
         buffer <= shifted;
         idx    <= idx + IDX_W'(1);
      end
   end
endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a standard FIFO and streams them as BYTE_W symbols over a
// valid/ready port, with back-to-back streaming and a completed-word counter.
module fifo_word_serializer
   import fifo_word_serializer_pkg::*;
#(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned BYTE_W    = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Enable,
   fifo_word_serializer_if.master bus,
   output logic                  Busy,
   output logic [CNT_W-1:0]      WordCount
);
   if ((WORD_W % BYTE_W) != 0 || WORD_W < BYTE_W) begin : g_bad_width
      $error("fifo_word_serializer: WORD_W must be a non-zero multiple of BYTE_W");
   end

   state_t            state;
   state_t            state_next;
   logic              xfer;
   logic              last;
   logic [BYTE_W-1:0] dout;

   assign xfer = (state == SEND) && bus.TxReady;

   piso_shift_reg #(
      .WORD_W   (WORD_W),
      .BYTE_W   (BYTE_W),
      .MSB_FIRST(MSB_FIRST)
   ) u_piso (
      .Clock(Clock),
      .Reset(Reset),
      .load (state == CAPTURE),
      .shift(xfer),
      .din  (bus.FifoData),
      .dout (dout),
      .last (last)
   );

   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (Enable && !bus.FifoEmpty) state_next = READ;
         READ:    state_next = CAPTURE;
         CAPTURE: state_next = SEND;
         SEND:    if (xfer && last)
                     state_next = (Enable && !bus.FifoEmpty) ? READ : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decode state only, so TxReady never reaches TxValid combinationally.
   always_comb begin
      bus.FifoReadEn = (state == READ);
      bus.TxValid    = (state == SEND);
      bus.TxData     = (state == SEND) ? dout : '0;
      Busy           = (state != IDLE);
   end

   always_ff @(posedge Clock) begin
      if (Reset)             WordCount <= '0;
      else if (xfer && last) WordCount <= WordCount + CNT_W'(1);
   end
endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: three serializer configurations fed from queue FIFO models,
// symbols checked in order against bytes queued when each word is pushed.
module tb_fifo_word_serializer;
   logic Clock = 1'b0;
   logic Reset, Enable, tx_ready;
   always #5 Clock = ~Clock;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   fifo_word_serializer_if #(.WORD_W(32), .BYTE_W(8))  ifa ();
   fifo_word_serializer_if #(.WORD_W(32), .BYTE_W(8))  ifb ();
   fifo_word_serializer_if #(.WORD_W(24), .BYTE_W(12)) ifc ();

   assign ifa.TxReady = tx_ready;
   assign ifb.TxReady = tx_ready;
   assign ifc.TxReady = tx_ready;

   logic        busy_a, busy_b, busy_c;
   logic [15:0] wc_a, wc_c;
   logic [1:0]  wc_b;

   fifo_word_serializer #(.WORD_W(32), .BYTE_W(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut_a (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .bus(ifa), .Busy(busy_a), .WordCount(wc_a));
   fifo_word_serializer #(.WORD_W(32), .BYTE_W(8), .MSB_FIRST(1'b0), .CNT_W(2)) dut_b (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .bus(ifb), .Busy(busy_b), .WordCount(wc_b));
   fifo_word_serializer #(.WORD_W(24), .BYTE_W(12), .MSB_FIRST(1'b1), .CNT_W(16)) dut_c (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .bus(ifc), .Busy(busy_c), .WordCount(wc_c));

   logic [31:0] fifo_a[$], fifo_b[$], fifo_c[$];
   logic [31:0] exp_a[$], exp_b[$], exp_c[$];
   int          read_cyc_a[$];
   int          cyc = 0;
   int          first_valid_a = -1;
   int unsigned reads_a = 0, xfer_a = 0;
   int unsigned ready_mode = 0;
   bit          pop_a, pop_b, pop_c, stall_a;
   logic [7:0]  last_a;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_a(input logic [31:0] w, input bit expect_now);
      fifo_a.push_back(w);
      ifa.FifoEmpty = 1'b0;
      if (expect_now)
         for (int i = 0; i < 4; i++) exp_a.push_back(32'(w[31-8*i -: 8]));
   endtask

   task automatic expect_a(input logic [31:0] w);
      for (int i = 0; i < 4; i++) exp_a.push_back(32'(w[31-8*i -: 8]));
   endtask

   task automatic push_b(input logic [31:0] w);
      fifo_b.push_back(w);
      ifb.FifoEmpty = 1'b0;
      for (int i = 0; i < 4; i++) exp_b.push_back(32'(w[8*i +: 8]));
   endtask

   task automatic push_c(input logic [31:0] w);
      fifo_c.push_back(w);
      ifc.FifoEmpty = 1'b0;
      for (int i = 0; i < 2; i++) exp_c.push_back(32'(w[23-12*i -: 12]));
   endtask

   // One clock: sample at the falling edge, update FIFO models just after the rising edge.
   task automatic step();
      @(negedge Clock);
      if (!Reset && stall_a) begin
         check("a_stall_valid", 32'(ifa.TxValid), 32'd1);
         check("a_stall_data", 32'(ifa.TxData), 32'(last_a));
      end
      if (!Reset && ifa.TxValid === 1'b1 && first_valid_a < 0) first_valid_a = cyc;
      if (!Reset && ifa.TxValid === 1'b1 && tx_ready) begin
         if (exp_a.size() == 0) check("a_unexpected_byte", 32'(exp_a.size()), 32'd1);
         else check("a_byte", 32'(ifa.TxData), exp_a.pop_front());
         xfer_a++;
      end
      stall_a = !Reset && ifa.TxValid === 1'b1 && !tx_ready;
      last_a  = ifa.TxData;
      if (!Reset && ifb.TxValid === 1'b1 && tx_ready) begin
         if (exp_b.size() == 0) check("b_unexpected_byte", 32'(exp_b.size()), 32'd1);
         else check("b_byte", 32'(ifb.TxData), exp_b.pop_front());
      end
      if (!Reset && ifc.TxValid === 1'b1 && tx_ready) begin
         if (exp_c.size() == 0) check("c_unexpected_sym", 32'(exp_c.size()), 32'd1);
         else check("c_sym", 32'(ifc.TxData), exp_c.pop_front());
      end
      pop_a = (ifa.FifoReadEn === 1'b1);
      pop_b = (ifb.FifoReadEn === 1'b1);
      pop_c = (ifc.FifoReadEn === 1'b1);
      if (pop_a) begin
         check("a_no_underflow", 32'(fifo_a.size() > 0), 32'd1);
         reads_a++;
         read_cyc_a.push_back(cyc);
      end
      if (pop_b) check("b_no_underflow", 32'(fifo_b.size() > 0), 32'd1);
      if (pop_c) check("c_no_underflow", 32'(fifo_c.size() > 0), 32'd1);
      @(posedge Clock);
      #1;
      cyc++;
      if (pop_a && fifo_a.size() > 0) ifa.FifoData = fifo_a.pop_front();
      if (pop_b && fifo_b.size() > 0) ifb.FifoData = fifo_b.pop_front();
      if (pop_c && fifo_c.size() > 0) ifc.FifoData = 24'(fifo_c.pop_front());
      ifa.FifoEmpty = (fifo_a.size() == 0);
      ifb.FifoEmpty = (fifo_b.size() == 0);
      ifc.FifoEmpty = (fifo_c.size() == 0);
      tx_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
   endtask

   task automatic run_until_idle(input string tag);
      bit done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (exp_a.size() == 0 && exp_b.size() == 0 && exp_c.size() == 0 &&
             !busy_a && !busy_b && !busy_c) begin
            done = 1'b1;
            break;
         end
         step();
      end
      check({tag, "_drained"}, 32'(done), 32'd1);
   endtask

   task automatic wait_xfers(input int unsigned target, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (xfer_a >= target) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check({tag, "_reached"}, 32'(ok), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0;
      int unsigned base;
      Reset = 1'b1; Enable = 1'b1; tx_ready = 1'b1;
      ifa.FifoData = '0; ifb.FifoData = '0; ifc.FifoData = '0;
      ifa.FifoEmpty = 1'b1; ifb.FifoEmpty = 1'b1; ifc.FifoEmpty = 1'b1;
      repeat (3) step();
      check("rst_readen", 32'(ifa.FifoReadEn), 32'd0);
      check("rst_txvalid", 32'(ifa.TxValid), 32'd0);
      check("rst_txdata", 32'(ifa.TxData), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_count", 32'(wc_a), 32'd0);
      Reset = 1'b0;
      step();

      // Single word, MSB-first (a), LSB-first (b), 12-bit symbols (c).
      t0 = cyc; read_cyc_a.delete(); first_valid_a = -1;
      push_a(32'hA1B2C3D4, 1'b1);
      push_b(32'hA1B2C3D4);
      push_c(32'h00ABC123);
      repeat (7) step();
      check("t1_read_latency", 32'(read_cyc_a.size() > 0 ? read_cyc_a[0] - t0 : -1), 32'd1);
      check("t1_valid_latency", 32'(first_valid_a - t0), 32'd3);
      check("t1_reads", 32'(reads_a), 32'd1);
      check("t1_bytes_left", 32'(exp_a.size()), 32'd0);
      check("t1_busy", 32'(busy_a), 32'd0);
      check("t1_count", 32'(wc_a), 32'd1);
      check("t2_lsb_bytes_left", 32'(exp_b.size()), 32'd0);
      check("t2_lsb_count", 32'(wc_b), 32'd1);
      check("t6_sym12_count", 32'(wc_c), 32'd1);

      // Backpressure: ready high one cycle in three.
      ready_mode = 1;
      push_a(32'h11223344, 1'b1);
      push_a(32'h55667788, 1'b1);
      push_c(32'h00DEF456);
      push_c(32'h00789ABC);
      run_until_idle("t3");
      ready_mode = 0;
      step();
      check("t3_count", 32'(wc_a), 32'd3);
      check("t3_sym12_count", 32'(wc_c), 32'd3);

      // Back-to-back streaming: pops every NBYTES+2 cycles.
      read_cyc_a.delete();
      push_a(32'h0F1E2D3C, 1'b1);
      push_a(32'h4B5A6978, 1'b1);
      push_a(32'h8796A5B4, 1'b1);
      for (int i = 0; i < 4; i++) push_b(32'hC0DE0000 | 32'(i));
      run_until_idle("t4");
      check("t4_reads", 32'(read_cyc_a.size()), 32'd3);
      if (read_cyc_a.size() == 3) begin
         check("t4_gap01", 32'(read_cyc_a[1] - read_cyc_a[0]), 32'd6);
         check("t4_gap12", 32'(read_cyc_a[2] - read_cyc_a[1]), 32'd6);
      end
      check("t4_count", 32'(wc_a), 32'd6);
      check("t6_cnt_wrap", 32'(wc_b), 32'd1);

      // Enable dropped mid-word: word finishes, queued word stays in the FIFO.
      base = xfer_a;
      reads_a = 0;
      push_a(32'hCAFEF00D, 1'b1);
      push_a(32'hBEEF1234, 1'b0);
      wait_xfers(base + 2, "t5");
      Enable = 1'b0;
      run_until_idle("t5");
      repeat (5) step();
      check("t5_reads", 32'(reads_a), 32'd1);
      check("t5_fifo_left", 32'(fifo_a.size()), 32'd1);
      check("t5_busy", 32'(busy_a), 32'd0);
      check("t5_count", 32'(wc_a), 32'd7);
      expect_a(32'hBEEF1234);
      Enable = 1'b1;
      run_until_idle("t5b");
      check("t5_count_resume", 32'(wc_a), 32'd8);

      // Reset while the third byte is presented.
      base = xfer_a;
      push_a(32'h99887766, 1'b1);
      wait_xfers(base + 2, "t6");
      check("t6_pre_valid", 32'(ifa.TxValid), 32'd1);
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      exp_a.delete();
      check("t6_rst_valid", 32'(ifa.TxValid), 32'd0);
      check("t6_rst_busy", 32'(busy_a), 32'd0);
      check("t6_rst_count", 32'(wc_a), 32'd0);
      check("t6_rst_data", 32'(ifa.TxData), 32'd0);
      reads_a = 0;
      repeat (4) step();
      check("t6_no_repop", 32'(reads_a), 32'd0);
      push_a(32'h13579BDF, 1'b1);
      run_until_idle("t6b");
      check("t6_count_after", 32'(wc_a), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
